i2s_audio_out: RTL and testbench
================================

# i2s_audio_out

Serialises the synthesizer's stereo output words (`lsound_out`/`rsound_out`) into a standard I2S stream for the audio codec DAC, generating bit clock and LR clock from `AUDIO_CLK`. Sits directly downstream of the synthesizer top. It double-buffers one stereo sample and issues a per-frame request pulse that drives the synthesizer's `trig` input. Underrun and overrun are flagged.

## Interface
Parameters:
- `AUD_BIT_DEPTH`, 24: sample width, two's complement.
- `SLOT_BITS`, 32: BCLK periods per channel slot; must be ≥ `AUD_BIT_DEPTH`+1.
- `BCLK_DIV`, 2: `AUDIO_CLK` cycles per BCLK half-period, ≥1.

Ports:
- `AUDIO_CLK`  in  1: sole clock.
- `reset_data`  in  1: **synchronous, active-high reset**.
- `lsound_in`  in  `AUD_BIT_DEPTH`: left sample.
- `rsound_in`  in  `AUD_BIT_DEPTH`: right sample.
- `sample_valid`  in  1: one-cycle strobe; the pair on `lsound_in`/`rsound_in` is valid in this cycle.
- `sample_req`  out  1: one-cycle pulse when the pending pair is consumed; drives synthesizer `trig`.
- `flag_clr`  in  1: clears sticky flags.
- `underrun`  out  1: sticky; frame started with no pending pair.
- `overrun`  out  1: sticky; `sample_valid` arrived while pending was full.
- `aud_bclk`  out  1: I2S bit clock.
- `aud_daclrck`  out  1: LR clock, 0 = left.
- `aud_dacdat`  out  1: serial data.

## Operation
- Divider `div_cnt` counts 0..`BCLK_DIV`-1. At terminal count, `aud_bclk` toggles. A toggle 1→0 is a "falling event".
- Bit counter `bit_cnt` is 0..2·`SLOT_BITS`-1 and advances on each falling event, wrapping to 0.
  - `aud_daclrck` = 1 when `bit_cnt` ≥ `SLOT_BITS`.
  - Both update on the falling event.
- Frame load happens on the falling event where `bit_cnt` wraps to 0:
  - If pending is full: copy pending into shift pair `l_sh`/`r_sh`, mark pending empty, pulse `sample_req`.
  - If pending is empty: reload the previous shift pair (repeat last sample), set `underrun`, pulse `sample_req` anyway.
- Data format (I2S, one-BCLK delay): at slot position k = `bit_cnt` mod `SLOT_BITS`:
  - k = 0: `aud_dacdat` = 0.
  - 1 ≤ k ≤ `AUD_BIT_DEPTH`: `aud_dacdat` = sample bit [`AUD_BIT_DEPTH`-k], MSB first.
  - Otherwise: `aud_dacdat` = 0.
  - Left slot uses `l_sh`; right slot uses `r_sh`. No sign extension or padding beyond this.
- Pending register:
  - `sample_valid` writes the pair and sets full.
  - If already full, the new pair overwrites and `overrun` is set.
  - `sample_valid` in the same cycle as a frame load: the load takes the old pending, the new pair is written, pending stays full, no overrun.
- Flags: `flag_clr` clears both flags. A simultaneous set wins over clear.

## Timing
- Reset values: `aud_bclk`=0, `aud_daclrck`=0, `aud_dacdat`=0, `sample_req`=0, `underrun`=0, `overrun`=0, `div_cnt`=0, `bit_cnt`=2·`SLOT_BITS`-1, pending empty, shift pair zero.
- First falling event after reset performs a frame load. With pending empty this flags `underrun`; this is expected and software clears it.
- All outputs are registered. `aud_dacdat`/`aud_daclrck` change in the same cycle `aud_bclk` goes 0, so the codec samples on the rising edge with a half-BCLK setup margin.
- BCLK period = 2·`BCLK_DIV` clocks. Frame = 4·`BCLK_DIV`·`SLOT_BITS` clocks; defaults give 256 clocks (48 kHz at 12.288 MHz).
- Latency: `sample_valid` at cycle t → pending at t+1. The left MSB appears on `aud_dacdat` one BCLK after the next frame-load falling event.
- `sample_req` is high for exactly one `AUDIO_CLK` cycle, coincident with the frame-load falling event.
- Reset asserted mid-frame aborts the frame immediately and returns all state to reset values on the next edge.

## Structure
- Shared package `audio_pkg`:
  - `typedef struct packed { logic [AUD_BIT_DEPTH-1:0] l, r; } stereo_t`.
  - Constant `I2S_SLOT_BITS` = 32.
- One sub-module `i2s_bclk_gen` (divider, `bit_cnt`, `aud_bclk`, `aud_daclrck`, falling-event and frame-start strobes).
- Pending/shift datapath and flags stay in the top.

## Test plan
- Reset, then steady `sample_valid` once per 256 clocks with L=0x800001, R=0x7FFFFE -> decoded I2S frames return exactly those values. `aud_dacdat`=0 at slot position 0 and positions 25–31. One `underrun` after reset only.
- LRCK/BCLK check, defaults -> BCLK period 4 clocks, LRCK period 256 clocks, LRCK edges coincide with BCLK falling.
- No `sample_valid` for 3 frames after loading L=0x123456 -> that pair repeats 3 times, `underrun`=1, `sample_req` pulses every 256 clocks.
- Two `sample_valid` within one frame (0x000001 then 0x000002) -> `overrun`=1, next frame carries 0x000002. `flag_clr` then clears both flags.
- `sample_valid` coincident with frame load -> old pending transmitted, new one in the following frame, `overrun` stays 0.
- `reset_data` asserted at `bit_cnt`=40 -> next cycle all outputs at reset values; first frame after release starts with LRCK=0.

Source files
------------

// File: rtl/audio_pkg.sv
// Shared audio types and constants for the I2S output path.
package audio_pkg;

    localparam int unsigned I2S_BIT_DEPTH = 24;
    localparam int unsigned I2S_SLOT_BITS = 32;

    typedef struct packed {
        logic [I2S_BIT_DEPTH-1:0] l;
        logic [I2S_BIT_DEPTH-1:0] r;
    } stereo_t;

    // Counter width able to hold 0..n-1, never narrower than one bit.
    function automatic int unsigned cnt_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/i2s_bclk_gen.sv
// Bit clock / LR clock generator with falling-event and frame-start strobes.
module i2s_bclk_gen
    import audio_pkg::*;
#(
    parameter int unsigned SLOT_BITS = I2S_SLOT_BITS,
    parameter int unsigned BCLK_DIV  = 2,
    localparam int unsigned CNT_W    = cnt_width(2 * SLOT_BITS)
) (
    input  logic             clk,
    input  logic             rst,
    output logic             bclk,
    output logic             lrck,
    output logic             fall_evt,
    output logic             frame_start,
    output logic [CNT_W-1:0] bit_nxt
);

    localparam int unsigned      DIV_W    = cnt_width(BCLK_DIV);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(BCLK_DIV - 1);
    localparam logic [CNT_W-1:0] BIT_LAST = CNT_W'(2 * SLOT_BITS - 1);
    localparam logic [CNT_W-1:0] SLOT_C   = CNT_W'(SLOT_BITS);

    logic [DIV_W-1:0] div_cnt;
    logic [CNT_W-1:0] bit_cnt;
    logic             div_tc;

    // Strobes fire in the cycle whose closing edge drives bclk low.
    always_comb begin
        div_tc      = (div_cnt == DIV_LAST);
        fall_evt    = div_tc & bclk;
        frame_start = fall_evt & (bit_cnt == BIT_LAST);
        bit_nxt     = (bit_cnt == BIT_LAST) ? '0 : bit_cnt + 1'b1;
    end

    // Divider, bit clock, bit position and LR clock.
    always_ff @(posedge clk) begin
        if (rst) begin
            div_cnt <= '0;
            bclk    <= 1'b0;
            bit_cnt <= BIT_LAST;
            lrck    <= 1'b0;
        end else begin
            div_cnt <= div_tc ? '0 : div_cnt + 1'b1;
            if (div_tc) begin
                bclk <= ~bclk;
            end
            if (fall_evt) begin
                bit_cnt <= bit_nxt;
                lrck    <= (bit_nxt >= SLOT_C);
            end
        end
    end

endmodule

// File: rtl/i2s_audio_out.sv
// I2S serialiser: double-buffers one stereo pair and streams it to the DAC.
module i2s_audio_out
    import audio_pkg::*;
#(
    parameter int unsigned AUD_BIT_DEPTH = 24,
    parameter int unsigned SLOT_BITS     = I2S_SLOT_BITS,
    parameter int unsigned BCLK_DIV      = 2
) (
    input  logic                     AUDIO_CLK,
    input  logic                     reset_data,
    input  logic [AUD_BIT_DEPTH-1:0] lsound_in,
    input  logic [AUD_BIT_DEPTH-1:0] rsound_in,
    input  logic                     sample_valid,
    output logic                     sample_req,
    input  logic                     flag_clr,
    output logic                     underrun,
    output logic                     overrun,
    output logic                     aud_bclk,
    output logic                     aud_daclrck,
    output logic                     aud_dacdat
);

    localparam int unsigned      CNT_W   = cnt_width(2 * SLOT_BITS);
    localparam logic [CNT_W-1:0] SLOT_C  = CNT_W'(SLOT_BITS);
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(AUD_BIT_DEPTH);

    typedef struct packed {
        logic [AUD_BIT_DEPTH-1:0] l;
        logic [AUD_BIT_DEPTH-1:0] r;
    } pair_t;

    pair_t                    pend;
    logic                     pend_full;
    logic [AUD_BIT_DEPTH-1:0] l_sh;
    logic [AUD_BIT_DEPTH-1:0] r_sh;

    logic                     fall_evt;
    logic                     frame_start;
    logic [CNT_W-1:0]         bit_nxt;
    logic [CNT_W-1:0]         slot_pos;
    logic [CNT_W-1:0]         sh_amt;
    logic [AUD_BIT_DEPTH-1:0] slot_word;
    logic [AUD_BIT_DEPTH-1:0] shifted;
    logic                     next_dat;
    logic                     set_ur;
    logic                     set_ov;

    i2s_bclk_gen #(
        .SLOT_BITS (SLOT_BITS),
        .BCLK_DIV  (BCLK_DIV)
    ) u_bclk_gen (
        .clk         (AUDIO_CLK),
        .rst         (reset_data),
        .bclk        (aud_bclk),
        .lrck        (aud_daclrck),
        .fall_evt    (fall_evt),
        .frame_start (frame_start),
        .bit_nxt     (bit_nxt)
    );

    // Serial bit for the slot position being entered; one-BCLK I2S delay, MSB first.
    always_comb begin
        slot_pos  = (bit_nxt >= SLOT_C) ? bit_nxt - SLOT_C : bit_nxt;
        slot_word = (bit_nxt >= SLOT_C) ? r_sh : l_sh;
        sh_amt    = DEPTH_C - slot_pos;
        shifted   = slot_word >> sh_amt;
        next_dat  = (slot_pos != '0 && slot_pos <= DEPTH_C) ? shifted[0] : 1'b0;
        set_ur    = frame_start & ~pend_full;
        // A write landing on a frame load refills the slot just emptied.
        set_ov    = sample_valid & pend_full & ~frame_start;
    end

    // Pending buffer, frame load into the shift pair, and serial data.
    always_ff @(posedge AUDIO_CLK) begin
        if (reset_data) begin
            pend       <= '0;
            pend_full  <= 1'b0;
            l_sh       <= '0;
            r_sh       <= '0;
            sample_req <= 1'b0;
            aud_dacdat <= 1'b0;
        end else begin
            sample_req <= frame_start;
            // On underrun the shift pair is left alone, so the last sample repeats.
            if (frame_start && pend_full) begin
                l_sh <= pend.l;
                r_sh <= pend.r;
            end
            if (sample_valid) begin
                pend      <= {lsound_in, rsound_in};
                pend_full <= 1'b1;
            end else if (frame_start) begin
                pend_full <= 1'b0;
            end
            if (fall_evt) begin
                aud_dacdat <= next_dat;
            end
        end
    end

    // Sticky status flags; a set in the same cycle as a clear wins.
    always_ff @(posedge AUDIO_CLK) begin
        if (reset_data) begin
            underrun <= 1'b0;
            overrun  <= 1'b0;
        end else begin
            underrun <= set_ur | (underrun & ~flag_clr);
            overrun  <= set_ov | (overrun & ~flag_clr);
        end
    end

endmodule

// File: tb/tb_i2s_audio_out.sv
// Self-checking bench for i2s_audio_out: edge-count reference model plus I2S decoder.
module tb_i2s_audio_out;
    import audio_pkg::*;

    localparam int D          = 24;
    localparam int S          = 32;
    localparam int DIV        = 2;
    localparam int FRAME_BITS = 2 * S;
    localparam int FRAME_CLKS = 4 * DIV * S;

    logic         clk = 1'b0;
    logic         reset_data = 1'b1;
    logic         sample_valid = 1'b0;
    logic         flag_clr = 1'b0;
    logic [D-1:0] lsound_in = '0;
    logic [D-1:0] rsound_in = '0;
    logic         sample_req, underrun, overrun, aud_bclk, aud_daclrck, aud_dacdat;

    int tests = 0;
    int failed = 0;
    int cyc = 0;

    always #5 clk = ~clk;

    i2s_audio_out #(
        .AUD_BIT_DEPTH (D),
        .SLOT_BITS     (S),
        .BCLK_DIV      (DIV)
    ) dut (
        .AUDIO_CLK    (clk),
        .reset_data   (reset_data),
        .lsound_in    (lsound_in),
        .rsound_in    (rsound_in),
        .sample_valid (sample_valid),
        .sample_req   (sample_req),
        .flag_clr     (flag_clr),
        .underrun     (underrun),
        .overrun      (overrun),
        .aud_bclk     (aud_bclk),
        .aud_daclrck  (aud_daclrck),
        .aud_dacdat   (aud_dacdat)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            if (failed <= 40)
                $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic chk_bit(input string name, input logic act, input logic exp);
        chk(name, {31'b0, act}, {31'b0, exp});
    endtask

    // ---------------- reference model: everything derived from edges since reset ----
    int           e = 0;
    bit           mvalid = 0;
    logic [D-1:0] m_pl = '0, m_pr = '0, m_sl = '0, m_sr = '0;
    logic         m_full = 1'b0;
    logic         x_bclk = 0, x_lr = 0, x_dat = 0, x_req = 0, x_ur = 0, x_ov = 0;

    always @(posedge clk) begin : model
        int           f, bitc, k;
        logic         load, fall, s_ur, s_ov;
        logic [D-1:0] word, tmp;
        mvalid = 1;
        if (reset_data) begin
            e = 0; m_full = 0; m_pl = '0; m_pr = '0; m_sl = '0; m_sr = '0;
            x_bclk = 0; x_lr = 0; x_dat = 0; x_req = 0; x_ur = 0; x_ov = 0;
        end else begin
            e++;
            fall   = (e % (2 * DIV)) == 0;
            f      = e / (2 * DIV);                 // falling events so far
            load   = fall && ((f % FRAME_BITS) == 1);
            x_bclk = ((e / DIV) % 2) == 1;
            x_req  = load;
            s_ur   = load && !m_full;
            s_ov   = sample_valid && m_full && !load;
            if (load && m_full) begin
                m_sl = m_pl;
                m_sr = m_pr;
            end
            if (sample_valid) begin
                m_pl = lsound_in; m_pr = rsound_in; m_full = 1;
            end else if (load) begin
                m_full = 0;
            end
            x_ur = s_ur ? 1'b1 : (flag_clr ? 1'b0 : x_ur);
            x_ov = s_ov ? 1'b1 : (flag_clr ? 1'b0 : x_ov);
            if (fall) begin
                bitc = (f - 1) % FRAME_BITS;
                x_lr = bitc >= S;
                k    = bitc % S;
                word = x_lr ? m_sr : m_sl;
                x_dat = 1'b0;
                if (k >= 1 && k <= D) begin
                    tmp   = word >> (D - k);
                    x_dat = tmp[0];
                end
            end
        end
    end

    // ---------------- compare, decoder and timing monitors -------------------------
    logic         pb = 0, plr = 0, armed = 0, last_lr = 1;
    int           pos = 0;
    logic [D-1:0] dword = '0, cur_l = '0;
    logic [D-1:0] ql[$];
    logic [D-1:0] qr[$];
    int           last_brise = -1, bclk_period = 0;
    int           last_lrrise = -1, lr_period = 0, lr_bad = 0;
    int           last_req = -1, req_int = 0;

    always @(negedge clk) begin
        cyc++;
        if (mvalid) begin
            chk_bit("aud_bclk", aud_bclk, x_bclk);
            chk_bit("aud_daclrck", aud_daclrck, x_lr);
            chk_bit("aud_dacdat", aud_dacdat, x_dat);
            chk_bit("sample_req", sample_req, x_req);
            chk_bit("underrun", underrun, x_ur);
            chk_bit("overrun", overrun, x_ov);
        end
        if (e == 0) begin
            armed = 0;
        end else begin
            if (sample_req && !armed) begin
                armed = 1;
                last_lr = 1;
            end
            if (armed && !pb && aud_bclk) begin
                if (aud_daclrck != last_lr) pos = 0;
                else pos++;
                last_lr = aud_daclrck;
                if (pos >= 1 && pos <= D) dword = {dword[D-2:0], aud_dacdat};
                if (pos == D) begin
                    if (!aud_daclrck) begin
                        cur_l = dword;
                    end else begin
                        ql.push_back(cur_l);
                        qr.push_back(dword);
                    end
                end
            end
        end
        if (!pb && aud_bclk) begin
            if (last_brise >= 0) bclk_period = cyc - last_brise;
            last_brise = cyc;
        end
        if (aud_daclrck != plr) begin
            if (!(pb && !aud_bclk)) lr_bad++;
            if (aud_daclrck) begin
                if (last_lrrise >= 0) lr_period = cyc - last_lrrise;
                last_lrrise = cyc;
            end
        end
        if (sample_req) begin
            if (last_req >= 0) req_int = cyc - last_req;
            last_req = cyc;
        end
        pb  = aud_bclk;
        plr = aud_daclrck;
    end

    // ---------------- stimulus helpers ---------------------------------------------
    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic pulse_valid(input logic [D-1:0] l, input logic [D-1:0] r);
        lsound_in = l; rsound_in = r; sample_valid = 1'b1;
        @(negedge clk);
        sample_valid = 1'b0;
    endtask

    task automatic pulse_clr();
        flag_clr = 1'b1;
        @(negedge clk);
        flag_clr = 1'b0;
    endtask

    task automatic wait_req();
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!sample_req && n < 2 * FRAME_CLKS);
        chk_bit("req_seen", sample_req, 1'b1);
    endtask

    task automatic chk_pair(input string name, input int back,
                            input logic [D-1:0] l, input logic [D-1:0] r);
        int n = ql.size();
        chk({name, "_avail"}, 32'(n > back), 32'd1);
        if (n > back) begin
            chk({name, "_l"}, {8'b0, ql[n-1-back]}, {8'b0, l});
            chk({name, "_r"}, {8'b0, qr[n-1-back]}, {8'b0, r});
        end
    endtask

    // ---------------- test sequence -------------------------------------------------
    initial begin
        int n;
        reset_data = 1'b1;
        tick(3);
        chk_bit("rst_bclk", aud_bclk, 1'b0);
        chk_bit("rst_lrck", aud_daclrck, 1'b0);
        chk_bit("rst_dat", aud_dacdat, 1'b0);
        chk_bit("rst_req", sample_req, 1'b0);
        chk_bit("rst_ur", underrun, 1'b0);
        chk_bit("rst_ov", overrun, 1'b0);
        reset_data = 1'b0;

        // Steady feed: one underrun after reset only.
        wait_req();
        chk_bit("p1_first_underrun", underrun, 1'b1);
        pulse_clr();
        for (int i = 0; i < 5; i++) begin
            tick(20);
            pulse_valid(24'h800001, 24'h7FFFFE);
            wait_req();
        end
        chk_pair("p1_frame", 0, 24'h800001, 24'h7FFFFE);
        chk_pair("p1_prev", 1, 24'h800001, 24'h7FFFFE);
        chk_bit("p1_no_underrun", underrun, 1'b0);

        // Clock geometry.
        chk("bclk_period", 32'(bclk_period), 32'd4);
        chk("lrck_period", 32'(lr_period), 32'd256);
        chk("lrck_edge_off_fall", 32'(lr_bad), 32'd0);
        chk("req_interval", 32'(req_int), 32'd256);

        // Underrun: one pair then silence for three frames.
        pulse_clr();
        wait_req();
        tick(10);
        pulse_valid(24'h123456, 24'h654321);
        repeat (5) wait_req();
        for (int i = 0; i < 4; i++) chk_pair("p3_repeat", i, 24'h123456, 24'h654321);
        chk_bit("p3_underrun", underrun, 1'b1);
        chk("p3_req_interval", 32'(req_int), 32'd256);

        // Overrun: two writes in one frame, the later one wins.
        pulse_clr();
        wait_req();
        tick(10);
        pulse_valid(24'h000001, 24'h000001);
        tick(10);
        pulse_valid(24'h000002, 24'h000002);
        chk_bit("p4_overrun", overrun, 1'b1);
        wait_req();
        wait_req();
        chk_pair("p4_last_wins", 0, 24'h000002, 24'h000002);
        pulse_clr();
        chk_bit("p4_clr_ur", underrun, 1'b0);
        chk_bit("p4_clr_ov", overrun, 1'b0);

        // Write coincident with a frame load.
        wait_req();
        tick(10);
        pulse_valid(24'hABCDEF, 24'h13579B);
        tick(244);
        pulse_valid(24'h2468AC, 24'hFEDCBA);
        chk_bit("p5_coincident_req", sample_req, 1'b1);
        chk_bit("p5_no_overrun", overrun, 1'b0);
        wait_req();
        wait_req();
        chk_pair("p5_old", 1, 24'hABCDEF, 24'h13579B);
        chk_pair("p5_new", 0, 24'h2468AC, 24'hFEDCBA);
        chk_bit("p5_no_overrun_end", overrun, 1'b0);

        // Reset while bit position 40 is on the wire.
        wait_req();
        tick(161);
        reset_data = 1'b1;
        @(negedge clk);
        chk_bit("p6_bclk", aud_bclk, 1'b0);
        chk_bit("p6_lrck", aud_daclrck, 1'b0);
        chk_bit("p6_dat", aud_dacdat, 1'b0);
        chk_bit("p6_req", sample_req, 1'b0);
        chk_bit("p6_ur", underrun, 1'b0);
        chk_bit("p6_ov", overrun, 1'b0);
        reset_data = 1'b0;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!sample_req && n < 20);
        chk("p6_first_req_delay", 32'(n), 32'd4);
        chk_bit("p6_first_lrck", aud_daclrck, 1'b0);

        // Randomised traffic against the model.
        for (int i = 0; i < 20 * FRAME_CLKS; i++) begin
            sample_valid = ($urandom_range(0, 149) == 0);
            lsound_in    = D'($urandom);
            rsound_in    = D'($urandom);
            flag_clr     = ($urandom_range(0, 299) == 0);
            @(negedge clk);
        end
        sample_valid = 1'b0;
        flag_clr     = 1'b0;
        tick(2);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
